// File: rtl/gpu_pipe_pkg.sv
// Shared constants and helpers for the GPU retiming pipeline blocks.
package gpu_pipe_pkg;

    localparam int GPU_DATA_W = 32;

    // Widest valid vector popcount accepts; callers zero-extend into it.
    localparam int POP_MAX_W = 64;

    function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] bits);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            if (bits[i]) cnt++;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/pipe_reg_stage.sv
// One elastic stage: a valid/data register that loads whenever it is empty
// or its downstream neighbour is ready.
module pipe_reg_stage
    import gpu_pipe_pkg::*;
#(
    parameter int WIDTH = GPU_DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             dn_ready,
    output logic             rdy,
    output logic             v,
    output logic [WIDTH-1:0] d
);

    logic             v_q, v_d;
    logic [WIDTH-1:0] d_q, d_d;

    assign rdy = !v_q || dn_ready;
    assign v   = v_q;
    assign d   = d_q;

    always_comb begin
        // NOTE: hold values are assigned first so no path leaves v_d/d_d unassigned (no latch).
        v_d = v_q;
        d_d = d_q;
        if (rdy) begin
            v_d = up_valid;
            if (up_valid) d_d = up_data;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use <= so every stage samples its neighbour's pre-edge value.
        if (!rst_n) begin
            // NOTE: the data register is reset too, so out_data reads 0 after reset.
            v_q <= 1'b0;
            d_q <= '0;
        end else if (flush) begin
            v_q <= 1'b0;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

endmodule

// File: rtl/pipe_reg_chain.sv
// DEPTH-stage elastic register pipeline with valid/ready backpressure,
// bubble collapsing, synchronous flush and a registered occupancy count.
module pipe_reg_chain
    import gpu_pipe_pkg::*;
#(
    parameter  int WIDTH = GPU_DATA_W,
    parameter  int DEPTH = 2,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [OCC_W-1:0] occupancy
);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] v_nxt;
    logic [WIDTH-1:0] d [DEPTH];

    logic [OCC_W-1:0]     occ_q, occ_d;
    logic [POP_MAX_W-1:0] pop_in;

    // Each stage's ready lives in its own generate block so the ready chain
    // is a series of distinct nets rather than one self-referencing vector.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             stage_rdy;
        logic             dn_rdy;
        logic             up_v;
        logic [WIDTH-1:0] up_d;

        if (i == 0) begin : g_head
            assign up_v = in_valid && in_ready;
            assign up_d = in_data;
        end else begin : g_body
            assign up_v = v[i-1];
            assign up_d = d[i-1];
        end

        if (i == DEPTH - 1) begin : g_tail
            assign dn_rdy = out_ready;
        end else begin : g_link
            assign dn_rdy = g_stage[i+1].stage_rdy;
        end

        pipe_reg_stage #(.WIDTH(WIDTH)) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush    (flush),
            .up_valid (up_v),
            .up_data  (up_d),
            .dn_ready (dn_rdy),
            .rdy      (stage_rdy),
            .v        (v[i]),
            .d        (d[i])
        );

        // Mirror of the stage's next valid bit, used only for occupancy.
        assign v_nxt[i] = !flush && (stage_rdy ? up_v : v[i]);
    end

    assign in_ready  = g_stage[0].stage_rdy && !flush && rst_n;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
    assign occupancy = occ_q;

    always_comb begin
        pop_in            = '0;
        pop_in[DEPTH-1:0] = v_nxt;
        occ_d             = OCC_W'(popcount(pop_in));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) occ_q <= '0;
        else        occ_q <= occ_d;
    end

endmodule
